bram_bank_writer: RTL and testbench



---
 rtl/bram_pkg.sv | 15 +
 rtl/bram_bank_writer.sv | 165 ++++++++++++++++
 tb/tb_bram_bank_writer.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bram_pkg.sv
// Shared types and default geometry for the banked BRAM block and its write sequencer.
package bram_pkg;

  localparam int BRAM_ADDR_WIDTH_DEF = 10;
  localparam int BANK_DATA_WIDTH_DEF = 8;
  localparam int BANK_CNT_DEF        = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    PAD  = 2'd2,
    DONE = 2'd3
  } writer_state_t;

endpackage

// File: rtl/bram_bank_writer.sv
// Scatters a valid/ready byte stream round-robin across BANK_CNT banks at a shared word
// address, padding the final partial word and counting words per frame.
module bram_bank_writer
  import bram_pkg::*;
#(
  parameter int BRAM_ADDR_WIDTH = BRAM_ADDR_WIDTH_DEF,
  parameter int BANK_DATA_WIDTH = BANK_DATA_WIDTH_DEF,
  parameter int BANK_CNT        = BANK_CNT_DEF,
  parameter logic [BANK_DATA_WIDTH-1:0] PAD_VALUE = '0
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic [BRAM_ADDR_WIDTH-1:0] base_addr,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [BANK_DATA_WIDTH-1:0] s_data,
  input  logic                       s_last,
  output logic [BRAM_ADDR_WIDTH-1:0] wr_addr,
  output logic [BANK_CNT-1:0]        wr_en,
  output logic [BANK_DATA_WIDTH-1:0] din,
  output logic                       busy,
  output logic                       done,
  output logic [BRAM_ADDR_WIDTH:0]   word_count,
  output logic                       overflow
);

  localparam int SEL_W = (BANK_CNT > 1) ? $clog2(BANK_CNT) : 1;
  localparam logic [SEL_W-1:0]           SEL_LAST  = SEL_W'(BANK_CNT - 1);
  localparam logic [SEL_W-1:0]           SEL_ONE   = SEL_W'(1);
  localparam logic [BRAM_ADDR_WIDTH-1:0] ADDR_ONE  = BRAM_ADDR_WIDTH'(1);
  localparam logic [BRAM_ADDR_WIDTH:0]   CNT_ONE   = (BRAM_ADDR_WIDTH + 1)'(1);
  localparam logic [BRAM_ADDR_WIDTH:0]   CNT_LIMIT = CNT_ONE << BRAM_ADDR_WIDTH;

  writer_state_t state_reg, state_next;

  logic [SEL_W-1:0]           bank_sel_reg, bank_sel_next;
  logic [BRAM_ADDR_WIDTH-1:0] cur_addr_reg, cur_addr_next;
  logic [BRAM_ADDR_WIDTH:0]   word_cnt_reg, word_cnt_next;
  logic                       overflow_reg, overflow_next;

  logic [BRAM_ADDR_WIDTH-1:0] wr_addr_reg;
  logic [BANK_CNT-1:0]        wr_en_reg;
  logic [BANK_DATA_WIDTH-1:0] din_reg;
  logic                       done_reg;
  logic [BRAM_ADDR_WIDTH:0]   word_count_reg;

  logic                accept;
  logic                write_byte;
  logic                pad_write;
  logic                word_end;
  logic [BANK_CNT-1:0] sel_hot;

  assign accept     = s_valid && (state_reg == FILL);
  assign write_byte = accept && !overflow_reg;
  assign pad_write  = (state_reg == PAD);
  assign word_end   = (write_byte || pad_write) && (bank_sel_reg == SEL_LAST);

  genvar gi;
  generate
    for (gi = 0; gi < BANK_CNT; gi++) begin : g_hot
      assign sel_hot[gi] = (bank_sel_reg == SEL_W'(gi));
    end
  endgenerate

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (start) state_next = FILL;
      FILL: begin
        if (accept && s_last) begin
          state_next = (overflow_reg || bank_sel_reg == SEL_LAST) ? DONE : PAD;
        end
      end
      PAD:  if (bank_sel_reg == SEL_LAST) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    s_ready = (state_reg == FILL);
    busy    = (state_reg != IDLE);
  end

  // Once the address space is exhausted, further bytes are accepted but never written.
  always_comb begin
    bank_sel_next = bank_sel_reg;
    cur_addr_next = cur_addr_reg;
    word_cnt_next = word_cnt_reg;
    overflow_next = overflow_reg;
    if (state_reg == IDLE && start) begin
      bank_sel_next = '0;
      cur_addr_next = base_addr;
      word_cnt_next = '0;
      overflow_next = 1'b0;
    end else if (write_byte || pad_write) begin
      if (word_end) begin
        bank_sel_next = '0;
        cur_addr_next = cur_addr_reg + ADDR_ONE;
        word_cnt_next = word_cnt_reg + CNT_ONE;
        if (write_byte && !s_last && (word_cnt_reg + CNT_ONE) == CNT_LIMIT) begin
          overflow_next = 1'b1;
        end
      end else begin
        bank_sel_next = bank_sel_reg + SEL_ONE;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bank_sel_reg <= '0;
      cur_addr_reg <= '0;
      word_cnt_reg <= '0;
      overflow_reg <= 1'b0;
    end else begin
      bank_sel_reg <= bank_sel_next;
      cur_addr_reg <= cur_addr_next;
      word_cnt_reg <= word_cnt_next;
      overflow_reg <= overflow_next;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_addr_reg    <= '0;
      wr_en_reg      <= '0;
      din_reg        <= '0;
      done_reg       <= 1'b0;
      word_count_reg <= '0;
    end else begin
      wr_en_reg <= '0;
      done_reg  <= (state_reg == DONE);
      if (write_byte) begin
        wr_en_reg   <= sel_hot;
        wr_addr_reg <= cur_addr_reg;
        din_reg     <= s_data;
      end else if (pad_write) begin
        wr_en_reg   <= sel_hot;
        wr_addr_reg <= cur_addr_reg;
        din_reg     <= PAD_VALUE;
      end
      if (state_reg == DONE) begin
        word_count_reg <= word_cnt_reg;
      end
    end
  end

  assign wr_addr    = wr_addr_reg;
  assign wr_en      = wr_en_reg;
  assign din        = din_reg;
  assign done       = done_reg;
  assign word_count = word_count_reg;
  assign overflow   = overflow_reg;

endmodule

// File: tb/tb_bram_bank_writer.sv
// Directed frame table plus hand-written reset/idle sequences for bram_bank_writer.
module tb_bram_bank_writer;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       start;
  logic [9:0] base_addr;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_last;

  logic       m_s_ready, m_busy, m_done, m_overflow;
  logic [9:0] m_wr_addr;
  logic [3:0] m_wr_en;
  logic [7:0] m_din;
  logic [10:0] m_word_count;

  logic       o_s_ready, o_busy, o_done, o_overflow;
  logic [1:0] o_wr_addr;
  logic [3:0] o_wr_en;
  logic [7:0] o_din;
  logic [2:0] o_word_count;

  logic        sel_ov;
  logic        mon_ready, mon_busy, mon_done, mon_ov;
  logic [9:0]  mon_addr;
  logic [3:0]  mon_en;
  logic [7:0]  mon_din;
  logic [10:0] mon_wc;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  bram_bank_writer #(
    .BRAM_ADDR_WIDTH(10), .BANK_DATA_WIDTH(8), .BANK_CNT(4), .PAD_VALUE(8'hAA)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .s_valid(s_valid), .s_ready(m_s_ready), .s_data(s_data), .s_last(s_last),
    .wr_addr(m_wr_addr), .wr_en(m_wr_en), .din(m_din), .busy(m_busy),
    .done(m_done), .word_count(m_word_count), .overflow(m_overflow)
  );

  bram_bank_writer #(
    .BRAM_ADDR_WIDTH(2), .BANK_DATA_WIDTH(8), .BANK_CNT(4), .PAD_VALUE(8'h00)
  ) dut_ov (
    .clock(clock), .reset_n(reset_n), .start(start), .base_addr(base_addr[1:0]),
    .s_valid(s_valid), .s_ready(o_s_ready), .s_data(s_data), .s_last(s_last),
    .wr_addr(o_wr_addr), .wr_en(o_wr_en), .din(o_din), .busy(o_busy),
    .done(o_done), .word_count(o_word_count), .overflow(o_overflow)
  );

  always_comb begin
    if (sel_ov) begin
      mon_ready = o_s_ready;
      mon_busy  = o_busy;
      mon_done  = o_done;
      mon_ov    = o_overflow;
      mon_addr  = {8'd0, o_wr_addr};
      mon_en    = o_wr_en;
      mon_din   = o_din;
      mon_wc    = {8'd0, o_word_count};
    end else begin
      mon_ready = m_s_ready;
      mon_busy  = m_busy;
      mon_done  = m_done;
      mon_ov    = m_overflow;
      mon_addr  = m_wr_addr;
      mon_en    = m_wr_en;
      mon_din   = m_din;
      mon_wc    = m_word_count;
    end
  end

  typedef struct {
    bit         ovdut;   // run against the 4-word instance
    logic [9:0] base;
    int         n;
    logic [7:0] first;
    logic [31:0] gaps;   // bit k set: s_valid low in frame cycle k
    int         exp_wc;
    bit         exp_ov;
  } frame_t;

  frame_t frames[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_frame(input frame_t f);
    int i, cyc, mod_words, word, npad, lastw;
    logic v;
    logic [7:0] exp_d;
    sel_ov = f.ovdut;
    mod_words = f.ovdut ? 4 : 1024;
    @(negedge clock);
    base_addr = f.base;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("ready_after_start", mon_ready, 1);
    chk("busy_in_frame", mon_busy, 1);
    chk("ov_cleared", mon_ov, 0);
    i = 0;
    cyc = 0;
    while (i < f.n && cyc < 200) begin
      v = !f.gaps[cyc % 32];
      s_valid = v;
      s_data = f.first + 8'(i);
      s_last = (i == f.n - 1);
      @(negedge clock);
      word = i / 4;
      if (v && word < mod_words) begin
        exp_d = f.first + 8'(i);
        chk("wr_en", mon_en, 1 << (i % 4));
        chk("wr_addr", mon_addr, (int'(f.base) + word) % mod_words);
        chk("din", mon_din, exp_d);
      end else begin
        chk("wr_en_no_write", mon_en, 0);
      end
      if (v) i++;
      cyc++;
    end
    s_valid = 1'b0;
    s_last = 1'b0;
    chk("frame_bytes_accepted", i, f.n);
    chk("ready_after_last", mon_ready, 0);
    npad = (4 - f.n % 4) % 4;
    lastw = (f.n - 1) / 4;
    for (int p = 0; p < npad; p++) begin
      @(negedge clock);
      chk("pad_en", mon_en, 1 << ((f.n % 4) + p));
      chk("pad_addr", mon_addr, (int'(f.base) + lastw) % mod_words);
      chk("pad_din", mon_din, 8'hAA);
      chk("pad_ready", mon_ready, 0);
      chk("done_early", mon_done, 0);
    end
    @(negedge clock);
    chk("done_pulse", mon_done, 1);
    chk("done_wr_en", mon_en, 0);
    chk("word_count", mon_wc, f.exp_wc);
    chk("overflow", mon_ov, f.exp_ov);
    chk("busy_after_done", mon_busy, 0);
    @(negedge clock);
    chk("done_single", mon_done, 0);
    chk("word_count_hold", mon_wc, f.exp_wc);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    frames[0] = '{ovdut: 0, base: 10'd5,    n: 8,  first: 8'h10, gaps: 32'h0,     exp_wc: 2, exp_ov: 0};
    frames[1] = '{ovdut: 0, base: 10'd20,   n: 6,  first: 8'h30, gaps: 32'h0,     exp_wc: 2, exp_ov: 0};
    frames[2] = '{ovdut: 0, base: 10'd100,  n: 12, first: 8'h50, gaps: 32'h00000A52, exp_wc: 3, exp_ov: 0};
    frames[3] = '{ovdut: 0, base: 10'd1023, n: 8,  first: 8'h70, gaps: 32'h0,     exp_wc: 2, exp_ov: 0};
    frames[4] = '{ovdut: 1, base: 10'd0,    n: 20, first: 8'h80, gaps: 32'h0,     exp_wc: 4, exp_ov: 1};
    frames[5] = '{ovdut: 1, base: 10'd2,    n: 16, first: 8'hC0, gaps: 32'h0,     exp_wc: 4, exp_ov: 0};
    frames[6] = '{ovdut: 0, base: 10'd7,    n: 1,  first: 8'hE0, gaps: 32'h0,     exp_wc: 1, exp_ov: 0};

    sel_ov = 1'b0;
    reset_n = 1'b0;
    start = 1'b0;
    base_addr = '0;
    s_valid = 1'b0;
    s_data = '0;
    s_last = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_ready", mon_ready, 0);
    chk("rst_wr_en", mon_en, 0);
    chk("rst_busy", mon_busy, 0);
    chk("rst_word_count", mon_wc, 0);
    reset_n = 1'b1;
    @(negedge clock);

    for (int k = 0; k < 7; k++) begin
      run_frame(frames[k]);
      $display("frame %0d: base=%0d bytes=%0d word_count=%0d overflow=%0b", k,
               frames[k].base, frames[k].n, mon_wc, mon_ov);
    end

    // Reset in the middle of a frame: abort, no padding, start ignored while held.
    sel_ov = 1'b0;
    @(negedge clock);
    base_addr = 10'd40;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      s_valid = 1'b1;
      s_data = 8'(k + 1);
      @(negedge clock);
    end
    s_valid = 1'b0;
    reset_n = 1'b0;
    start = 1'b1;
    #1;
    chk("mid_rst_ready", mon_ready, 0);
    chk("mid_rst_wr_en", mon_en, 0);
    chk("mid_rst_wr_addr", mon_addr, 0);
    chk("mid_rst_din", mon_din, 0);
    chk("mid_rst_busy", mon_busy, 0);
    chk("mid_rst_done", mon_done, 0);
    chk("mid_rst_word_count", mon_wc, 0);
    chk("mid_rst_overflow", mon_ov, 0);
    @(negedge clock);
    chk("rst_start_ignored", mon_busy, 0);
    start = 1'b0;
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      chk("post_rst_no_write", mon_en, 0);
      chk("post_rst_idle", mon_busy, 0);
    end
    $display("reset mid-frame sequence done");
    run_frame(frames[0]);
    $display("clean frame after reset: word_count=%0d", mon_wc);

    // s_valid in IDLE is never accepted.
    @(negedge clock);
    s_valid = 1'b1;
    s_data = 8'h5A;
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      chk("idle_no_write", mon_en, 0);
      chk("idle_not_ready", mon_ready, 0);
    end
    s_valid = 1'b0;
    $display("idle s_valid sequence done");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
